// File: rtl/mem_bus_pkg.sv
// Shared bus types and constants for the mem_responder memory target.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word array with byte enables; contents are never
// reset so the array can be mapped onto block RAM.
module mem_responder_ram
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [STRB_W-1:0] be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // rdata_q only moves on an enabled read, so it holds steady for the response
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (be[i]) begin
            mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Handshaked, fixed-latency memory responder: one request at a time, word
// access to an internal RAM. Define MEM_RESPONDER_BYTE_STROBE_EN for byte-lane writes.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int               DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int               LATENCY   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]        CNT_INIT   = 4'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] WORD_LIMIT = ADDR_W'(DEPTH);

  state_e state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rd_ok_q, rd_ok_d;
  logic              hold_we_q, hold_we_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;

  logic [ADDR_W-1:0] word_off;
  logic              misaligned;
  logic              access_err;
  logic              ram_en;
  logic              ram_en_gated;
  logic [STRB_W-1:0] ram_be;
  logic [DATA_W-1:0] ram_rdata;

`ifdef MEM_RESPONDER_BYTE_STROBE_EN
  logic [STRB_W-1:0] hold_wstrb_q, hold_wstrb_d;
  assign ram_be = hold_wstrb_q;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^req_wstrb;
  assign ram_be       = '1;
`endif

  // Decode works on the held request, so late changes on req_* cannot leak in
  assign word_off   = (hold_addr_q - BASE_ADDR) >> 2;
  assign misaligned = |(hold_addr_q[1:0] & MISALIGN_MASK);
  assign access_err = misaligned || (word_off >= WORD_LIMIT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rd_ok_d      = rd_ok_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
    hold_wstrb_d = hold_wstrb_q;
`endif
    ram_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          hold_we_d    = req_we;
          hold_addr_d  = req_addr;
          hold_wdata_d = req_wdata;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
          hold_wstrb_d = req_wstrb;
`endif
          cnt_d        = CNT_INIT;
          req_ready_d  = 1'b0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          ram_en      = !access_err;
          rsp_valid_d = 1'b1;
          rsp_err_d   = access_err;
          rd_ok_d     = !access_err && !hold_we_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rd_ok_d     = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reset landing on the commit edge must still suppress the RAM write
  assign ram_en_gated = ram_en && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_ok_q     <= rd_ok_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_we_q    <= hold_we_d;
    hold_addr_q  <= hold_addr_d;
    hold_wdata_q <= hold_wdata_d;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
    hold_wstrb_q <= hold_wstrb_d;
`endif
  end

  mem_responder_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en_gated),
    .we    (hold_we_q),
    .be    (ram_be),
    .idx   (word_off[IDX_W-1:0]),
    .wdata (hold_wdata_q),
    .rdata (ram_rdata)
  );

  // RAM output register feeds the port directly; the flag blanks it for writes and errors
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder against a behavioural
// memory model; honours MEM_RESPONDER_BYTE_STROBE_EN when defined.
module tb_mem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          LAT   = 3;
  localparam int          LIMIT = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model_mem [DEPTH];
  bit          strobe_en;

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  function automatic bit model_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 != 0) || ((off / 4) >= DEPTH);
  endfunction

  // Expected response for a transaction; applies the write to the model
  function automatic logic [31:0] model_access(input logic we, input logic [31:0] a,
                                               input logic [31:0] d, input logic [3:0] s);
    int idx;
    logic [31:0] w;
    if (model_err(a)) return 32'h0;
    idx = int'((a - BASE) / 4);
    if (!we) return model_mem[idx];
    w = model_mem[idx];
    for (int b = 0; b < 4; b++)
      if (!strobe_en || s[b]) w = (w & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
    model_mem[idx] = w;
    return 32'h0;
  endfunction

  // Drive one transaction; stall = cycles of rsp_ready=0 after rsp_valid
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int stall, input bit pulse,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output bit ready_leak, output bit unstable, output bit post_ok);
    int w;
    ready_leak = 0; unstable = 0; post_ok = 0;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < LIMIT) begin @(negedge clk); w++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_wstrb = 4'($urandom);
    lat = 0;
    while (!rsp_valid && lat < LIMIT) begin
      if (req_ready) ready_leak = 1;
      @(negedge clk); lat++;
    end
    rdata = rsp_rdata; err = rsp_err;
    for (int i = 0; i < stall; i++) begin
      if (req_ready) ready_leak = 1;
      if (pulse && i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'd4; req_wdata = ~model_mem[1];
        req_wstrb = 4'hF;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err) unstable = 1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    post_ok = (req_ready === 1'b1) && (rsp_valid === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] rd, d; logic er; int lat; bit leak, unst, post; int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      void'(model_access(1'b1, BASE + 32'(4*i), d, 4'hF));
      run_txn(1'b1, BASE + 32'(4*i), d, 4'hF, 0, 0, rd, er, lat, leak, unst, post);
      if (er !== 1'b0 || lat != LAT || !post) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("[TB] FAIL fill: got %0d bad writes expected 0", bad); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat; bit leak, unst, post;
    void'(model_access(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF));
    run_txn(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lat, leak, unst, post);
    tests_run++; if (rd !== 32'h0 || er !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_rsp: got rdata %h err %b expected 0/0", rd, er); end
    tests_run++; if (lat != LAT) begin tests_failed++; $display("[TB] FAIL wr_latency: got %0d expected %0d", lat, LAT); end
    run_txn(1'b0, BASE + 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat, leak, unst, post);
    tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("[TB] FAIL rd_data: got %h expected deadbeef", rd); end
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("[TB] FAIL rd_err: got %b expected 0", er); end
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic er; int lat; bit leak, unst, post;
    run_txn(1'b0, BASE + 32'h24, 32'h0, 4'h0, 0, 0, rd, er, lat, leak, unst, post);
    tests_run++; if (lat != LAT) begin tests_failed++; $display("[TB] FAIL latency: got %0d expected %0d", lat, LAT); end
    tests_run++; if (leak) begin tests_failed++; $display("[TB] FAIL ready_busy: got req_ready 1 expected 0 while busy"); end
    tests_run++; if (!post) begin tests_failed++; $display("[TB] FAIL post_handshake: got ready/valid %b/%b expected 1/0", req_ready, rsp_valid); end
    tests_run++; if (rd !== model_mem[9]) begin tests_failed++; $display("[TB] FAIL lat_rdata: got %h expected %h", rd, model_mem[9]); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit leak, unst, post; logic [31:0] a;
    run_txn(1'b0, BASE + 32'h13, 32'h0, 4'h0, 0, 0, rd, er, lat, leak, unst, post);
    tests_run++; if (er !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL err_misalign: got err %b rdata %h expected 1/0", er, rd); end
    a = BASE + 32'(4*DEPTH);
    run_txn(1'b1, a, 32'hFFFF_FFFF, 4'hF, 0, 0, rd, er, lat, leak, unst, post);
    tests_run++; if (er !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_range: got %b expected 1", er); end
    run_txn(1'b0, BASE, 32'h0, 4'h0, 0, 0, rd, er, lat, leak, unst, post);
    tests_run++; if (rd !== model_mem[0] || er !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_word0: got %h expected %h", rd, model_mem[0]); end
    run_txn(1'b0, BASE - 32'd4, 32'h0, 4'h0, 0, 0, rd, er, lat, leak, unst, post);
    tests_run++; if (er !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_below_base: got %b expected 1", er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; bit leak, unst, post; bit extra;
    run_txn(1'b0, BASE + 32'h8, 32'h0, 4'h0, 5, 1, rd, er, lat, leak, unst, post);
    tests_run++; if (unst) begin tests_failed++; $display("[TB] FAIL bp_stable: got changing response expected stable"); end
    tests_run++; if (leak) begin tests_failed++; $display("[TB] FAIL bp_ready: got req_ready 1 expected 0 during stall"); end
    tests_run++; if (rd !== model_mem[2]) begin tests_failed++; $display("[TB] FAIL bp_rdata: got %h expected %h", rd, model_mem[2]); end
    extra = 0;
    for (int i = 0; i < LAT + 3; i++) begin @(negedge clk); if (rsp_valid) extra = 1; end
    tests_run++; if (extra) begin tests_failed++; $display("[TB] FAIL bp_ignored: got spurious response expected none"); end
    run_txn(1'b0, BASE + 32'h4, 32'h0, 4'h0, 0, 0, rd, er, lat, leak, unst, post);
    tests_run++; if (rd !== model_mem[1]) begin tests_failed++; $display("[TB] FAIL bp_no_write: got %h expected %h", rd, model_mem[1]); end
  endtask

  task automatic test_strobe();
    logic [31:0] rd, exp; logic er; int lat; bit leak, unst, post;
    void'(model_access(1'b1, BASE + 32'h20, 32'h11223344, 4'hF));
    run_txn(1'b1, BASE + 32'h20, 32'h11223344, 4'hF, 0, 0, rd, er, lat, leak, unst, post);
    void'(model_access(1'b1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101));
    run_txn(1'b1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, rd, er, lat, leak, unst, post);
    exp = strobe_en ? 32'h11BB33DD : 32'hAABBCCDD;
    run_txn(1'b0, BASE + 32'h20, 32'h0, 4'h0, 0, 0, rd, er, lat, leak, unst, post);
    tests_run++; if (rd !== exp) begin tests_failed++; $display("[TB] FAIL strobe_0101: got %h expected %h", rd, exp); end
    void'(model_access(1'b1, BASE + 32'h20, 32'h0BAD0BAD, 4'b0000));
    run_txn(1'b1, BASE + 32'h20, 32'h0BAD0BAD, 4'b0000, 0, 0, rd, er, lat, leak, unst, post);
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("[TB] FAIL strobe_zero_err: got %b expected 0", er); end
    run_txn(1'b0, BASE + 32'h20, 32'h0, 4'h0, 0, 0, rd, er, lat, leak, unst, post);
    tests_run++; if (rd !== model_mem[8]) begin tests_failed++; $display("[TB] FAIL strobe_zero: got %h expected %h", rd, model_mem[8]); end
  endtask

  // Reset is sampled at edge E+delay after the write is accepted at edge E
  task automatic test_reset_wait(input int delay);
    logic [31:0] rd; logic er; int lat; bit leak, unst, post; bit rose;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h8; req_wdata = 32'h5A5A5A5A; req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rose = 0;
    for (int i = 1; i < delay; i++) begin @(negedge clk); if (rsp_valid) rose = 1; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_wait_ready_d%0d: got %b expected 1", delay, req_ready); end
    for (int i = 0; i < LAT + 3; i++) begin if (rsp_valid) rose = 1; @(negedge clk); end
    tests_run++; if (rose) begin tests_failed++; $display("[TB] FAIL rst_wait_valid_d%0d: got rsp_valid 1 expected 0", delay); end
    run_txn(1'b0, BASE + 32'h8, 32'h0, 4'h0, 0, 0, rd, er, lat, leak, unst, post);
    tests_run++; if (rd !== model_mem[2]) begin tests_failed++; $display("[TB] FAIL rst_wait_data_d%0d: got %h expected %h", delay, rd, model_mem[2]); end
  endtask

  task automatic test_random(input int n);
    logic [31:0] rd, a, d, exp; logic er, we; logic [3:0] s; int lat, kind; bit leak, unst, post; bit exp_err;
    for (int t = 0; t < n; t++) begin
      kind = $urandom_range(0, 9);
      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      if (kind == 8) a = a + 32'($urandom_range(1, 3));
      if (kind == 9) a = $urandom;
      we = 1'($urandom); d = $urandom; s = 4'($urandom);
      exp_err = model_err(a);
      exp = model_access(we, a, d, s);
      run_txn(we, a, d, s, $urandom_range(0, 3), 0, rd, er, lat, leak, unst, post);
      tests_run++;
      if (rd !== exp || er !== exp_err || lat != LAT || unst || leak || !post) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d: got rdata %h err %b lat %0d expected %h %b %0d (addr %h we %b)",
                 t, rd, er, lat, exp, exp_err, LAT, a, we);
      end
    end
  endtask

  initial begin
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
    strobe_en = 1'b1;
`else
    strobe_en = 1'b0;
`endif
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; rsp_ready = 1'b0;
    test_reset();
    test_fill();
    test_write_read();
    test_latency();
    test_errors();
    test_backpressure();
    test_strobe();
    test_reset_wait(2);
    test_reset_wait(LAT);
    test_random(60);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
